memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 122 ++++++++++++
 tb/tb_memory_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage with a word-addressed data memory and a
// fixed multi-cycle load latency. Stores complete in one cycle; loads stall
// the pipeline for LOAD_LATENCY-1 cycles and then write back.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   RegWriteM, MemtoRegM,     EX/MEM control (load = MemtoRegM & RegWriteM)
//   MemWriteM
//   ALUOutM                   byte address for loads/stores, or ALU result
//   WriteDataM                store data
//   WriteRegM                 destination register
//   StallMem                  combinational, high while a load is pending
//   RegWriteW, MemtoRegW,     MEM/WB registers
//   ReadDataW, ALUOutW,
//   WriteRegW, MisalignW
//   ResultW                   combinational writeback mux
module memory_stage #(
    parameter int DEPTH        = 256,
    parameter int LOAD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        StallMem,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        MisalignW,
    output logic [31:0] ResultW
);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [2:0] LAST  = 3'(LOAD_LATENCY - 1);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       ld_data;
    logic [IDX_W-1:0]  idx;
    logic              misalign;
    logic              is_load;
    logic [31:0]       rd_now;
    logic              unused_addr_bits;

    assign idx      = ALUOutM[IDX_W+1:2];
    assign misalign = |ALUOutM[1:0];
    assign is_load  = MemtoRegM & RegWriteM;
    assign rd_now   = misalign ? 32'h0 : mem[idx];

    // Address bits above the index are deliberately ignored (wrap-around).
    assign unused_addr_bits = ^ALUOutM[31:IDX_W+2];

    always_comb begin
        StallMem = 1'b0;
        if (state == IDLE)
            StallMem = is_load && (LOAD_LATENCY > 1);
        else
            StallMem = (cnt < LAST);
    end

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

    // Stores only commit from IDLE; in LOAD_WAIT the held inputs are the
    // same instruction, whose store already happened at issue.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && MemWriteM && !misalign)
            mem[idx] <= WriteDataM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            MisalignW <= 1'b0;
            ReadDataW <= 32'h0;
            ALUOutW   <= 32'h0;
            WriteRegW <= 5'd0;
            ld_data   <= 32'h0;
        end else if (state == IDLE) begin
            if (is_load && LOAD_LATENCY > 1) begin
                // Capture the read now so a store paired with this load
                // (written at this same edge) does not leak into the result.
                ld_data   <= rd_now;
                state     <= LOAD_WAIT;
                cnt       <= 3'd1;
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
                MisalignW <= 1'b0;
            end else begin
                RegWriteW <= RegWriteM;
                MemtoRegW <= MemtoRegM;
                ALUOutW   <= ALUOutM;
                WriteRegW <= WriteRegM;
                MisalignW <= misalign & (MemWriteM | is_load);
                ReadDataW <= is_load ? rd_now : 32'h0;
            end
        end else begin
            if (cnt < LAST) begin
                cnt <= cnt + 3'd1;
            end else begin
                RegWriteW <= RegWriteM;
                MemtoRegW <= MemtoRegM;
                ALUOutW   <= ALUOutM;
                WriteRegW <= WriteRegM;
                MisalignW <= misalign;
                ReadDataW <= ld_data;
                state     <= IDLE;
                cnt       <= 3'd0;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: a LOAD_LATENCY=2 instance driven through a
// scoreboard, and a LOAD_LATENCY=4 instance used for reset-abort behaviour.
module tb_memory_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---- main DUT (DEPTH=256, LOAD_LATENCY=2)
    logic        rst = 1'b1;
    logic        RegWriteM = 0, MemtoRegM = 0, MemWriteM = 0;
    logic [31:0] ALUOutM = 0, WriteDataM = 0;
    logic [4:0]  WriteRegM = 0;
    logic        StallMem, RegWriteW, MemtoRegW, MisalignW;
    logic [31:0] ReadDataW, ALUOutW, ResultW;
    logic [4:0]  WriteRegW;

    memory_stage #(.DEPTH(256), .LOAD_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .StallMem(StallMem), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
        .MisalignW(MisalignW), .ResultW(ResultW)
    );

    // ---- second DUT (LOAD_LATENCY=4)
    logic        rst_4 = 1'b1;
    logic        rw4 = 0, m2r4 = 0, mw4 = 0;
    logic [31:0] a4 = 0, d4 = 0;
    logic [4:0]  wr4 = 0;
    logic        stall_4, rw_4, m2r_4, mis_4;
    logic [31:0] rd_4, alu_4, res_4;
    logic [4:0]  wreg_4;

    memory_stage #(.DEPTH(256), .LOAD_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst_4),
        .RegWriteM(rw4), .MemtoRegM(m2r4), .MemWriteM(mw4),
        .ALUOutM(a4), .WriteDataM(d4), .WriteRegM(wr4),
        .StallMem(stall_4), .RegWriteW(rw_4), .MemtoRegW(m2r_4),
        .ReadDataW(rd_4), .ALUOutW(alu_4), .WriteRegW(wreg_4),
        .MisalignW(mis_4), .ResultW(res_4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        rw, m2r, mis;
        logic [31:0] rd, alu, res;
        logic [4:0]  wr;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [256];

    // Drive one instruction, predict its writeback, wait out any stall and
    // compare the W stage against the popped prediction.
    task automatic issue(input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        exp_t e, g;
        int   st;
        logic ld, mis;
        @(negedge clk);
        RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
        ALUOutM = a; WriteDataM = d; WriteRegM = r;
        ld  = rw & m2r;
        mis = |a[1:0];
        e.rw = rw; e.m2r = m2r; e.alu = a; e.wr = r;
        e.mis = mis & (mw | ld);
        e.rd  = (ld && !mis) ? mdl[a[9:2]] : 32'h0;
        e.res = m2r ? e.rd : a;
        e.stalls = ld ? 1 : 0;
        if (mw && !mis) mdl[a[9:2]] = d;   // after the read: read-before-write
        sb.push_back(e);
        st = 0;
        #1;
        while (StallMem && st < 20) begin
            st++;
            @(negedge clk); #1;
            chk("bubble_rw", RegWriteW, 0);
        end
        @(posedge clk); #1;
        g = sb.pop_front();
        chk("stalls",  st,        g.stalls);
        chk("rw",      RegWriteW, g.rw);
        chk("m2r",     MemtoRegW, g.m2r);
        chk("rdata",   ReadDataW, g.rd);
        chk("alu",     ALUOutW,   g.alu);
        chk("wreg",    WriteRegW, g.wr);
        chk("mis",     MisalignW, g.mis);
        chk("result",  ResultW,   g.res);
    endtask

    initial begin
        int st;
        // ---- reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_stall", StallMem, 0);
        chk("rst_rw",    RegWriteW, 0);
        chk("rst_m2r",   MemtoRegW, 0);
        chk("rst_mis",   MisalignW, 0);
        chk("rst_rd",    ReadDataW, 0);
        chk("rst_alu",   ALUOutW, 0);
        chk("rst_wreg",  WriteRegW, 0);
        chk("rst_res",   ResultW, 0);
        rst = 1'b0;

        // ---- directed
        issue(0, 0, 1, 32'h10,  32'hDEADBEEF, 0);   // store
        issue(1, 0, 0, 32'h1234, 0, 3);              // ALU op
        issue(1, 1, 0, 32'h10,  0, 5);               // load -> DEADBEEF
        issue(0, 0, 1, 32'h13,  32'h11111111, 0);   // misaligned store
        issue(1, 1, 0, 32'h10,  0, 6);               // unchanged
        issue(0, 0, 1, 32'h400, 32'h55, 0);          // wraps to word 0
        issue(1, 1, 0, 32'h000, 0, 7);               // -> 0x55
        issue(0, 0, 1, 32'h20,  32'hA5A5, 0);
        issue(1, 1, 1, 32'h20,  32'h77, 8);          // load+store: old data
        issue(1, 1, 0, 32'h20,  0, 9);               // -> 0x77
        issue(1, 1, 0, 32'h22,  0, 10);              // misaligned load

        // ---- random mix over a prefilled window
        for (int w = 0; w < 16; w++) issue(0, 0, 1, 32'(w * 4), $urandom, 0);
        for (int n = 0; n < 30; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3) << 10);
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            case (kind)
                0: issue(0, 0, 1, a, $urandom, 0);
                1: issue(1, 1, 0, a, 0, 5'($urandom));
                default: issue(1, 0, 0, $urandom, 0, 5'($urandom));
            endcase
        end
        @(negedge clk);
        RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;

        // ---- LOAD_LATENCY=4: reset aborts a load in flight
        @(negedge clk); rst_4 = 0; mw4 = 1; a4 = 32'h10; d4 = 32'hCAFE0004;
        @(negedge clk); mw4 = 0; rw4 = 1; m2r4 = 1; wr4 = 5'd7;
        #1 chk("r4_stall1", stall_4, 1);
        @(negedge clk); #1 chk("r4_stall2", stall_4, 1);
        chk("r4_bubble", rw_4, 0);
        rst_4 = 1; rw4 = 0; m2r4 = 0; mw4 = 1; d4 = 32'h99;  // store in reset cycle
        @(posedge clk); #1;
        chk("r4_rst_rw",    rw_4, 0);
        chk("r4_rst_stall", stall_4, 0);
        @(negedge clk); rst_4 = 0; mw4 = 0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("r4_no_wb", rw_4, 0);
            chk("r4_idle_stall", stall_4, 0);
        end
        rw4 = 1; m2r4 = 1; a4 = 32'h10; wr4 = 5'd9;
        #1 st = 0;
        while (stall_4 && st < 20) begin
            st++;
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        chk("r4_stalls", st, 3);
        chk("r4_rw",     rw_4, 1);
        chk("r4_wreg",   wreg_4, 9);
        chk("r4_result", res_4, 32'hCAFE0004);
        @(negedge clk); rw4 = 0; m2r4 = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
